// File: rtl/block_collision_tracker_pkg.sv
// Shared constants, FSM state encodings and the packed-coordinate slice helper
// for the block collision tracker.
package block_collision_tracker_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned N_OBJ_DEF   = 25;
  localparam int unsigned N_BLK_DEF   = 20;
  localparam int unsigned OBJ_H       = 20;
  localparam int unsigned BALL_SZ     = 8;
  localparam int unsigned OFFSCREEN_X = 640;
  localparam int unsigned MAX_OBJ     = 32;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned BUS_MAX_W   = MAX_OBJ * COORD_W;
  localparam int unsigned BASE_W      = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SCAN   = 2'd1;
  localparam state_t ST_REPORT = 2'd2;

  // Extract coordinate field i from a packed per-object bus (zero-extended to MAX_OBJ).
  function automatic logic [COORD_W-1:0] coord_at(input logic [BUS_MAX_W-1:0] bus,
                                                  input logic [IDX_W-1:0]     i);
    logic [BASE_W-1:0] base;
    base = BASE_W'(i) * BASE_W'(COORD_W);
    return bus[base +: COORD_W];
  endfunction

endpackage

// File: rtl/block_collision_tracker_if.sv
// Bundle of frame/ball/object inputs and hit-report outputs of the tracker.
// master: drives frame_tick, clear, ball_x/y, obj_x/y/w; observes results.
// slave : the tracker; drives collision_ball, busy, done, bounce, hit_idx,
//         hit_count, all_cleared.
interface block_collision_tracker_if
  import block_collision_tracker_pkg::*;
#(
  parameter int unsigned N_OBJ = N_OBJ_DEF
);

  logic                     frame_tick;
  logic                     clear;
  logic [COORD_W-1:0]       ball_x;
  logic [COORD_W-1:0]       ball_y;
  logic [N_OBJ*COORD_W-1:0] obj_x;
  logic [N_OBJ*COORD_W-1:0] obj_y;
  logic [N_OBJ*COORD_W-1:0] obj_w;
  logic [N_OBJ-1:0]         collision_ball;
  logic                     busy;
  logic                     done;
  logic                     bounce;
  logic [IDX_W-1:0]         hit_idx;
  logic [CNT_W-1:0]         hit_count;
  logic                     all_cleared;

  modport master (
    output frame_tick, clear, ball_x, ball_y, obj_x, obj_y, obj_w,
    input  collision_ball, busy, done, bounce, hit_idx, hit_count, all_cleared
  );

  modport slave (
    input  frame_tick, clear, ball_x, ball_y, obj_x, obj_y, obj_w,
    output collision_ball, busy, done, bounce, hit_idx, hit_count, all_cleared
  );

endinterface

// File: rtl/block_collision_tracker_aabb_overlap.sv
// Combinational ball-vs-object rectangle overlap test in 11-bit unsigned
// arithmetic (no wrap). Touching edges do not count; objects parked at
// OFFSCREEN_X or beyond never overlap.
// Ports: bx/by ball top-left, ox/oy/ow object left/top/width, overlap_c result.
module aabb_overlap
  import block_collision_tracker_pkg::*;
(
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic [COORD_W-1:0] ow,
  output logic               overlap_c
);

  localparam int unsigned EXT_W = COORD_W + 1;

  logic [EXT_W-1:0] bx_e, by_e, ox_e, oy_e, ow_e;

  assign bx_e = EXT_W'(bx);
  assign by_e = EXT_W'(by);
  assign ox_e = EXT_W'(ox);
  assign oy_e = EXT_W'(oy);
  assign ow_e = EXT_W'(ow);

  assign overlap_c = (ox_e < EXT_W'(OFFSCREEN_X))
                  && ((bx_e + EXT_W'(BALL_SZ)) > ox_e)
                  && (bx_e < (ox_e + ow_e))
                  && ((by_e + EXT_W'(BALL_SZ)) > oy_e)
                  && (by_e < (oy_e + EXT_W'(OBJ_H)));

endmodule

// File: rtl/block_collision_tracker.sv
// Per-frame sequential scan of all objects against a snapshot of the ball,
// keeping a sticky destroyed vector and reporting one bounce request with
// first-hit index and hit count at the end of each scan.
// Ports: clk, rst (sync, active-high), bus (slave side of
// block_collision_tracker_if).
// Build option: ROCK_PERSIST_EN keeps rock bits (index >= N_BLK) at 0 while
// rocks still count as hits.
module block_collision_tracker
  import block_collision_tracker_pkg::*;
#(
  parameter int unsigned N_OBJ = N_OBJ_DEF,
  parameter int unsigned N_BLK = N_BLK_DEF
)(
  input  logic                     clk,
  input  logic                     rst,
  block_collision_tracker_if.slave bus
);

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [COORD_W-1:0] bx_q, by_q;
  logic [N_OBJ-1:0]   coll_q;
  logic [CNT_W-1:0]   cnt_q, hit_count_q;
  logic [IDX_W-1:0]   first_idx_q, hit_idx_q;
  logic               seen_q, busy_q, done_q, bounce_q, all_cleared_q;

  logic [COORD_W-1:0] ox_c, oy_c, ow_c;
  logic               overlap_c, hit_c, destroy_c, last_c;

  // Object selected by the scan index.
  assign ox_c = coord_at(BUS_MAX_W'(bus.obj_x), idx_q);
  assign oy_c = coord_at(BUS_MAX_W'(bus.obj_y), idx_q);
  assign ow_c = coord_at(BUS_MAX_W'(bus.obj_w), idx_q);

  aabb_overlap u_overlap (
    .bx        (bx_q),
    .by        (by_q),
    .ox        (ox_c),
    .oy        (oy_c),
    .ow        (ow_c),
    .overlap_c (overlap_c)
  );

  // Already-destroyed objects are skipped regardless of their x position.
  assign hit_c  = (state_q == ST_SCAN) && !coll_q[idx_q] && overlap_c;
  assign last_c = (idx_q == IDX_W'(N_OBJ - 1));

`ifdef ROCK_PERSIST_EN
  assign destroy_c = hit_c && (idx_q < IDX_W'(N_BLK));
`else
  assign destroy_c = hit_c;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; clear aborts any scan and blocks a new one.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (bus.frame_tick && !bus.clear) state_nxt = ST_SCAN;
      ST_SCAN:   if (bus.clear)                    state_nxt = ST_IDLE;
                 else if (last_c)                  state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot, scan bookkeeping, sticky vector and registered reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      coll_q        <= '0;
      cnt_q         <= '0;
      first_idx_q   <= '0;
      seen_q        <= 1'b0;
      hit_idx_q     <= '0;
      hit_count_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      bounce_q      <= 1'b0;
      all_cleared_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      bounce_q      <= 1'b0;
      busy_q        <= (state_nxt != ST_IDLE);
      all_cleared_q <= &coll_q[N_BLK-1:0];
      if (bus.clear) begin
        coll_q      <= '0;
        idx_q       <= '0;
        cnt_q       <= '0;
        first_idx_q <= '0;
        seen_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.frame_tick) begin
              bx_q        <= bus.ball_x;
              by_q        <= bus.ball_y;
              idx_q       <= '0;
              cnt_q       <= '0;
              first_idx_q <= '0;
              seen_q      <= 1'b0;
            end
          end
          ST_SCAN: begin
            if (destroy_c) coll_q[idx_q] <= 1'b1;
            if (hit_c) begin
              if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
              if (!seen_q) begin
                seen_q      <= 1'b1;
                first_idx_q <= idx_q;
              end
            end
            if (!last_c) idx_q <= idx_q + IDX_W'(1);
          end
          ST_REPORT: begin
            done_q      <= 1'b1;
            bounce_q    <= seen_q;
            hit_idx_q   <= first_idx_q;
            hit_count_q <= cnt_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.collision_ball = coll_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.bounce         = bounce_q;
  assign bus.hit_idx        = hit_idx_q;
  assign bus.hit_count      = hit_count_q;
  assign bus.all_cleared    = all_cleared_q;

endmodule

// File: tb/tb_block_collision_tracker.sv
// Self-checking bench for block_collision_tracker: directed edge cases plus
// randomized layouts/balls against a per-scan reference model.
module tb_block_collision_tracker;
  import block_collision_tracker_pkg::*;

  localparam int unsigned N  = N_OBJ_DEF;
  localparam int unsigned NB = N_BLK_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_collision_tracker_if #(.N_OBJ(N)) bus();

  block_collision_tracker #(.N_OBJ(N), .N_BLK(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ox[N];
  int oy[N];
  int ow[N];
  logic [N-1:0] m_coll;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_objs();
    logic [N*COORD_W-1:0] vx, vy, vw;
    for (int i = 0; i < int'(N); i++) begin
      vx[i*COORD_W +: COORD_W] = COORD_W'(ox[i]);
      vy[i*COORD_W +: COORD_W] = COORD_W'(oy[i]);
      vw[i*COORD_W +: COORD_W] = COORD_W'(ow[i]);
    end
    bus.obj_x = vx;
    bus.obj_y = vy;
    bus.obj_w = vw;
  endtask

  function automatic bit m_overlap(input int i, input int bx, input int by);
    return (ox[i] < int'(OFFSCREEN_X)) && (bx + int'(BALL_SZ) > ox[i]) &&
           (bx < ox[i] + ow[i]) && (by + int'(BALL_SZ) > oy[i]) &&
           (by < oy[i] + int'(OBJ_H));
  endfunction

  function automatic bit destroyable(input int i);
`ifdef ROCK_PERSIST_EN
    return i < int'(NB);
`else
    return (i >= 0);
`endif
  endfunction

  task automatic pulse_clear();
    @(negedge clk); bus.clear = 1'b1;
    @(negedge clk); bus.clear = 1'b0;
    m_coll = '0;
  endtask

  // One full scan with the ball at (bx,by); checks latency and all reports.
  task automatic run_scan(input int bx, input int by, input string tag);
    int  e_cnt = 0;
    int  e_idx = 0;
    bit  e_b   = 1'b0;
    int  cyc   = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (!m_coll[i] && m_overlap(i, bx, by)) begin
        if (!e_b) e_idx = i;
        e_b = 1'b1;
        if (e_cnt < 31) e_cnt++;
        if (destroyable(i)) m_coll[i] = 1'b1;
      end
    end
    @(negedge clk);
    bus.ball_x = COORD_W'(bx);
    bus.ball_y = COORD_W'(by);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.ball_x = COORD_W'($urandom);
    bus.ball_y = COORD_W'($urandom);
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 26);
    if (bus.done) begin
      chk({tag, "_bounce"}, 32'(bus.bounce), 32'(e_b));
      chk({tag, "_count"}, 32'(bus.hit_count), e_cnt);
      if (e_b) chk({tag, "_idx"}, 32'(bus.hit_idx), e_idx);
      chk({tag, "_coll"}, 32'(bus.collision_ball), 32'(m_coll));
      chk({tag, "_allclr"}, 32'(bus.all_cleared), 32'(&m_coll[NB-1:0]));
    end
  endtask

  task automatic park_all();
    for (int i = 0; i < int'(N); i++) begin
      ox[i] = int'(OFFSCREEN_X); oy[i] = 0; ow[i] = 10;
    end
  endtask

  initial begin
    int  bx, by, j, dones, busys;
    bit  seen;
    rst = 1'b1;
    bus.frame_tick = 1'b0; bus.clear = 1'b0;
    bus.ball_x = '0; bus.ball_y = '0;
    park_all();
    load_objs();
    m_coll = '0;
    repeat (3) @(negedge clk);
    chk("rst_coll",   32'(bus.collision_ball), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_bounce", 32'(bus.bounce), 0);
    chk("rst_idx",    32'(bus.hit_idx), 0);
    chk("rst_count",  32'(bus.hit_count), 0);
    chk("rst_allclr", 32'(bus.all_cleared), 0);
    rst = 1'b0;

    // Basic hit, then removed object, then sticky skip while still on screen.
    ox[0] = 30; oy[0] = 40; ow[0] = 60; load_objs();
    run_scan(50, 45, "t1");
    ox[0] = int'(OFFSCREEN_X); load_objs();
    run_scan(50, 45, "t2");
    ox[0] = 30; load_objs();
    run_scan(50, 45, "t2b");

    // Touching edges on all four sides, then a one-pixel overlap.
    pulse_clear();
    run_scan(90, 45, "edge_r");
    run_scan(22, 45, "edge_l");
    run_scan(50, 60, "edge_b");
    run_scan(50, 32, "edge_t");
    run_scan(89, 45, "edge_in");

    // Block and rock hit in one scan.
    pulse_clear();
    ox[0] = int'(OFFSCREEN_X);
    ox[3] = 100; oy[3] = 200; ow[3] = 40;
    ox[20] = 120; oy[20] = 200; ow[20] = 40;
    load_objs();
    run_scan(115, 205, "t4");

    // Clear mid-scan aborts; a frame_tick inside the scan is not queued.
    pulse_clear();
    @(negedge clk);
    bus.ball_x = 10'd115; bus.ball_y = 10'd205; bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      bus.frame_tick = (k == 5);
    end
    bus.frame_tick = 1'b0;
    chk("mc_pre_bit3", 32'(bus.collision_ball[3]), 1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("mc_busy", 32'(bus.busy), 0);
    chk("mc_coll", 32'(bus.collision_ball), 0);
    dones = 0; busys = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) busys++;
    end
    chk("mc_no_done", dones, 0);
    chk("mc_no_restart", busys, 0);
    m_coll = '0;

    // Clear wins over a simultaneous frame_tick.
    @(negedge clk);
    bus.clear = 1'b1; bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0; bus.frame_tick = 1'b0;
    chk("clr_prio_busy", 32'(bus.busy), 0);

    // Randomized layouts and balls.
    for (int s = 0; s < 40; s++) begin
      if (s % 10 == 0) begin
        for (int i = 0; i < int'(N); i++) begin
          ox[i] = int'($urandom_range(0, 700));
          oy[i] = int'($urandom_range(0, 460));
          ow[i] = int'($urandom_range(1, 80));
        end
        load_objs();
      end
      if ($urandom_range(0, 5) == 0) pulse_clear();
      j  = int'($urandom_range(0, N - 1));
      bx = ox[j] + int'($urandom_range(0, ow[j] + 16)) - 8;
      by = oy[j] + int'($urandom_range(0, 36)) - 8;
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      if (bx > 1015) bx = 1015;
      run_scan(bx, by, "rnd");
    end

    // Destroy every block; all_cleared follows the last bit by one cycle.
    pulse_clear();
    park_all();
    for (int i = 0; i < int'(NB); i++) begin
      ox[i] = 20 + (i % 10) * 60; oy[i] = 50 + (i / 10) * 40; ow[i] = 40;
    end
    load_objs();
    for (int i = 0; i < int'(NB) - 1; i++) run_scan(ox[i] + 10, oy[i] + 5, "ac");
    @(negedge clk);
    bus.ball_x = COORD_W'(ox[NB-1] + 10); bus.ball_y = COORD_W'(oy[NB-1] + 5);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.collision_ball[NB-1]) seen = 1'b1;
      else @(negedge clk);
    end
    chk("ac_last_set", 32'(seen), 1);
    chk("ac_before", 32'(bus.all_cleared), 0);
    @(negedge clk);
    chk("ac_after", 32'(bus.all_cleared), 1);
    for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
    m_coll[NB-1] = 1'b1;
    chk("ac_vec", 32'(bus.collision_ball), 32'(m_coll));

    // Reset in the middle of a scan.
    @(negedge clk); bus.frame_tick = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_coll",   32'(bus.collision_ball), 0);
    chk("rst2_busy",   32'(bus.busy), 0);
    chk("rst2_done",   32'(bus.done), 0);
    chk("rst2_bounce", 32'(bus.bounce), 0);
    chk("rst2_idx",    32'(bus.hit_idx), 0);
    chk("rst2_count",  32'(bus.hit_count), 0);
    chk("rst2_allclr", 32'(bus.all_cleared), 0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("rst2_no_done", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
